// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS32 core.
// Sequences fetch/decode/execute/memory/writeback over a shared memory port
// with MEM_WAIT extra cycles per access, and traps unsupported encodings.
// Outputs are registered from the next state, so each output reflects the
// state it is observed in (Moore behaviour with no output glitches).
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Link,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_RTWB, S_ADDIEXEC, S_ADDIWB, S_BEQ, S_JUMP, S_JAL, S_JR,
    S_TRAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);
  localparam logic [3:0]       ALU_ADD  = 4'b0010;

  state_t           state, state_nx, state_e;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_e;
  logic             wait_done;
  logic             rt_ok;
  logic [3:0]       rt_alu;

  logic       pcw_d, br_d, iord_d, mr_d, mw_d, irw_d, rw_d, rd_d, lk_d;
  logic       m2r_d, asa_d, ill_d;
  logic [1:0] asb_d, pcs_d;
  logic [3:0] alu_d;

  // R-type / special-op ALU decode and legality check
  always_comb begin
    rt_ok  = 1'b0;
    rt_alu = ALU_ADD;
    if (Opcode == 6'b011111) begin
      if (funct == 6'b010000 && shamt == 5'd0) begin
        rt_ok = 1'b1; rt_alu = 4'b1000;
      end else if (funct == 6'b010000 && shamt == 5'b00100) begin
        rt_ok = 1'b1; rt_alu = 4'b1001;
      end
    end else begin
      case (funct)
        6'b100000: begin rt_ok = 1'b1; rt_alu = 4'b0010; end
        6'b100010: begin rt_ok = 1'b1; rt_alu = 4'b0110; end
        6'b100100: begin rt_ok = 1'b1; rt_alu = 4'b0000; end
        6'b100101: begin rt_ok = 1'b1; rt_alu = 4'b0001; end
        6'b101010: begin rt_ok = 1'b1; rt_alu = 4'b0111; end
        6'b000100: begin rt_ok = 1'b1; rt_alu = 4'b1010; end
        6'b000110: if (shamt == 5'd0) begin rt_ok = 1'b1; rt_alu = 4'b1011; end
        6'b000111: if (shamt == 5'd0) begin rt_ok = 1'b1; rt_alu = 4'b1100; end
        default:   rt_ok = 1'b0;
      endcase
    end
  end

  // Next-state and wait-counter logic; memory states stay until the count expires
  always_comb begin
    state_nx  = state;
    cnt_nx    = '0;
    wait_done = (cnt == CNT_LAST);
    case (state)
      S_FETCH:
        if (wait_done) state_nx = S_DECODE;
        else           cnt_nx   = cnt + CNT_W'(1);
      S_DECODE:
        case (Opcode)
          6'b000000, 6'b011111: state_nx = S_RTEXEC;
          6'b100011, 6'b101011: state_nx = S_MEMADR;
          6'b000100:            state_nx = S_BEQ;
          6'b001000:            state_nx = S_ADDIEXEC;
          6'b000010:            state_nx = S_JUMP;
          6'b000011:            state_nx = S_JAL;
          6'b000111:            state_nx = S_JR;
          default:              state_nx = S_TRAP;
        endcase
      S_MEMADR:   state_nx = (Opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (wait_done) state_nx = S_MEMWB;
        else           cnt_nx   = cnt + CNT_W'(1);
      S_MEMWR:
        if (wait_done) state_nx = S_FETCH;
        else           cnt_nx   = cnt + CNT_W'(1);
      S_RTEXEC:   state_nx = rt_ok ? S_RTWB : S_TRAP;
      S_ADDIEXEC: state_nx = S_ADDIWB;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_FETCH;
    endcase
  end

  // Output decode for the state about to be entered (reset forces FETCH, count 0)
  always_comb begin
    state_e = reset ? S_FETCH : state_nx;
    cnt_e   = reset ? '0 : cnt_nx;
    pcw_d = 1'b0; br_d  = 1'b0; iord_d = 1'b0; mr_d  = 1'b0;
    mw_d  = 1'b0; irw_d = 1'b0; rw_d   = 1'b0; rd_d  = 1'b0;
    lk_d  = 1'b0; m2r_d = 1'b0; asa_d  = 1'b0; ill_d = 1'b0;
    asb_d = 2'b00; pcs_d = 2'b00; alu_d = ALU_ADD;
    case (state_e)
      S_FETCH: begin
        mr_d  = 1'b1;
        asb_d = 2'b01;
        if (cnt_e == CNT_LAST) begin
          irw_d = 1'b1;
          pcw_d = 1'b1;
        end
      end
      S_DECODE:   asb_d = 2'b11;
      S_MEMADR:   begin asa_d = 1'b1; asb_d = 2'b10; end
      S_MEMRD:    begin mr_d = 1'b1; iord_d = 1'b1; end
      S_MEMWB:    begin rw_d = 1'b1; m2r_d = 1'b1; end
      S_MEMWR:    begin mw_d = 1'b1; iord_d = 1'b1; end
      S_RTEXEC:   begin asa_d = 1'b1; alu_d = rt_alu; end
      S_RTWB:     begin rw_d = 1'b1; rd_d = 1'b1; end
      S_ADDIEXEC: begin asa_d = 1'b1; asb_d = 2'b10; end
      S_ADDIWB:   rw_d = 1'b1;
      S_BEQ:      begin asa_d = 1'b1; alu_d = 4'b0110; br_d = 1'b1; pcs_d = 2'b01; end
      S_JUMP:     begin pcw_d = 1'b1; pcs_d = 2'b10; end
      S_JAL:      begin pcw_d = 1'b1; pcs_d = 2'b10; rw_d = 1'b1; lk_d = 1'b1; end
      S_JR:       begin pcw_d = 1'b1; pcs_d = 2'b11; end
      S_TRAP:     ill_d = 1'b1;
      default:    ill_d = 1'b0;
    endcase
  end

  // State, counter and registered outputs; synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
    PCWrite    <= pcw_d;
    Branch     <= br_d;
    IorD       <= iord_d;
    MemRead    <= mr_d;
    MemWrite   <= mw_d;
    IRWrite    <= irw_d;
    RegWrite   <= rw_d;
    RegDst     <= rd_d;
    Link       <= lk_d;
    MemToReg   <= m2r_d;
    ALUSrcA    <= asa_d;
    ALUSrcB    <= asb_d;
    PCSrc      <= pcs_d;
    ALUControl <= alu_d;
    illegal    <= ill_d;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: three instances with
// MEM_WAIT = 0, 2, 3 share stimulus; one instance is checked at a time.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [19:0] o [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, br, iord, mr, mw, irw, rw, rd, lk, m2r, asa, ill;
    logic [1:0] asb, pcs;
    logic [3:0] alu;
    mips_multicycle_ctrl #(
      .MEM_WAIT((g == 0) ? 0 : (g == 1) ? 2 : 3),
      .CNT_W(4)
    ) u_dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .funct(funct), .shamt(shamt),
      .PCWrite(pcw), .Branch(br), .IorD(iord), .MemRead(mr), .MemWrite(mw),
      .IRWrite(irw), .RegWrite(rw), .RegDst(rd), .Link(lk), .MemToReg(m2r),
      .ALUSrcA(asa), .ALUSrcB(asb), .PCSrc(pcs), .ALUControl(alu),
      .illegal(ill)
    );
    assign o[g] = {pcw, br, iord, mr, mw, irw, rw, rd, lk, m2r, asa, asb, pcs, alu, ill};
  end

  function automatic logic [19:0] mk(input logic pcw, br, iord, mr, mw, irw, rw, rd, lk,
                                     m2r, asa, input logic [1:0] asb, pcs,
                                     input logic [3:0] alu, input logic ill);
    return {pcw, br, iord, mr, mw, irw, rw, rd, lk, m2r, asa, asb, pcs, alu, ill};
  endfunction

  //                               pcw br iord mr mw irw rw rd lk m2r asa asb    pcs    alu      ill
  function automatic logic [19:0] e_rtx(input logic [3:0] a);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, a, 0);
  endfunction

  logic [19:0] E_F, E_FL, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_RTWB;
  logic [19:0] E_AEX, E_AWB, E_BEQ, E_J, E_JAL, E_JR, E_TRAP;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] sh;
    logic [19:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb[$];
  int          sel;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic add(input logic rst, input logic [5:0] op, fn, input logic [4:0] sh,
                     input logic [19:0] e);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.sh = sh; v.exp = e;
    tbl.push_back(v);
  endtask

  // Full R-type / special-op instruction starting from a FETCH-last cycle
  task automatic add_rtype(input logic [5:0] op, fn, input logic [4:0] sh, input logic [3:0] a);
    add(0, op, fn, sh, E_DEC);
    add(0, op, fn, sh, e_rtx(a));
    add(0, op, fn, sh, E_RTWB);
    add(0, op, fn, sh, E_FL);
  endtask

  // Drive one cycle, queue its expectation, compare after the edge
  task automatic step(input logic rst, input logic [5:0] op, fn, input logic [4:0] sh,
                      input logic [19:0] e, input string name);
    logic [19:0] exp, act;
    reset = rst; Opcode = op; funct = fn; shamt = sh;
    sb.push_back(e);
    @(posedge clk);
    #1;
    act = o[sel];
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %05h", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
    end
  endtask

  initial begin
    E_F    = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010, 0);
    E_FL   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010, 0);
    E_DEC  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0010, 0);
    E_MADR = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0010, 0);
    E_MRD  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010, 0);
    E_MWB  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0010, 0);
    E_MWR  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010, 0);
    E_RTWB = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0010, 0);
    E_AEX  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0010, 0);
    E_AWB  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010, 0);
    E_BEQ  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'b0110, 0);
    E_J    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0010, 0);
    E_JAL  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b10, 4'b0010, 0);
    E_JR   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 4'b0010, 0);
    E_TRAP = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010, 1);

    // MEM_WAIT = 0 vector table
    add(1, 6'b000000, 6'b100000, 5'd0, E_FL);                 // reset state
    add_rtype(6'b000000, 6'b100000, 5'd0, 4'b0010);           // add
    add_rtype(6'b000000, 6'b100010, 5'd0, 4'b0110);           // sub
    add_rtype(6'b000000, 6'b101010, 5'd0, 4'b0111);           // slt
    add_rtype(6'b000000, 6'b000110, 5'd0, 4'b1011);           // shamt-0 op
    add_rtype(6'b011111, 6'b010000, 5'b00100, 4'b1001);       // special, shamt 4
    add_rtype(6'b011111, 6'b010000, 5'd0, 4'b1000);           // special, shamt 0
    add(0, 6'b000100, 6'd0, 5'd0, E_DEC);                     // beq
    add(0, 6'b000100, 6'd0, 5'd0, E_BEQ);
    add(0, 6'b000100, 6'd0, 5'd0, E_FL);
    add(0, 6'b000011, 6'd0, 5'd0, E_DEC);                     // jal
    add(0, 6'b000011, 6'd0, 5'd0, E_JAL);
    add(0, 6'b000011, 6'd0, 5'd0, E_FL);
    add(0, 6'b000010, 6'd0, 5'd0, E_DEC);                     // j
    add(0, 6'b000010, 6'd0, 5'd0, E_J);
    add(0, 6'b000010, 6'd0, 5'd0, E_FL);
    add(0, 6'b000111, 6'd0, 5'd0, E_DEC);                     // jr
    add(0, 6'b000111, 6'd0, 5'd0, E_JR);
    add(0, 6'b000111, 6'd0, 5'd0, E_FL);
    add(0, 6'b001000, 6'd0, 5'd0, E_DEC);                     // addi
    add(0, 6'b001000, 6'd0, 5'd0, E_AEX);
    add(0, 6'b001000, 6'd0, 5'd0, E_AWB);
    add(0, 6'b001000, 6'd0, 5'd0, E_FL);
    add(0, 6'b100011, 6'd0, 5'd0, E_DEC);                     // lw
    add(0, 6'b100011, 6'd0, 5'd0, E_MADR);
    add(0, 6'b100011, 6'd0, 5'd0, E_MRD);
    add(0, 6'b100011, 6'd0, 5'd0, E_MWB);
    add(0, 6'b100011, 6'd0, 5'd0, E_FL);
    add(0, 6'b101011, 6'd0, 5'd0, E_DEC);                     // sw
    add(0, 6'b101011, 6'd0, 5'd0, E_MADR);
    add(0, 6'b101011, 6'd0, 5'd0, E_MWR);
    add(0, 6'b101011, 6'd0, 5'd0, E_FL);
    add(0, 6'b011111, 6'b010000, 5'b00001, E_DEC);            // illegal special
    add(0, 6'b011111, 6'b010000, 5'b00001, e_rtx(4'b0010));
    add(0, 6'b011111, 6'b010000, 5'b00001, E_TRAP);
    add(0, 6'b011111, 6'b010000, 5'b00001, E_TRAP);
    add(1, 6'b000000, 6'b000110, 5'd3, E_FL);                 // reset clears trap
    add(0, 6'b000000, 6'b000110, 5'd3, E_DEC);                // shamt != 0 illegal
    add(0, 6'b000000, 6'b000110, 5'd3, e_rtx(4'b0010));
    add(0, 6'b000000, 6'b000110, 5'd3, E_TRAP);

    reset = 1'b1; Opcode = '0; funct = '0; shamt = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].sh, tbl[i].exp, $sformatf("vec%0d", i));

    // Unsupported opcode: trap is absorbing for 20 cycles, then reset recovers
    sel = 0;
    step(1, 6'b111111, 6'd0, 5'd0, E_FL, "bad_fetch");
    step(0, 6'b111111, 6'd0, 5'd0, E_DEC, "bad_decode");
    for (int i = 0; i < 20; i++)
      step(0, 6'b111111, 6'd0, 5'd0, E_TRAP, $sformatf("trap_hold%0d", i));
    step(1, 6'b111111, 6'd0, 5'd0, E_FL, "trap_reset");

    // lw with MEM_WAIT = 2: 3-cycle fetch, 3-cycle read, 9 cycles total
    sel = 1;
    step(1, 6'b100011, 6'd0, 5'd0, E_F,    "lw2_f0");
    step(0, 6'b100011, 6'd0, 5'd0, E_F,    "lw2_f1");
    step(0, 6'b100011, 6'd0, 5'd0, E_FL,   "lw2_f2");
    step(0, 6'b100011, 6'd0, 5'd0, E_DEC,  "lw2_dec");
    step(0, 6'b100011, 6'd0, 5'd0, E_MADR, "lw2_adr");
    for (int i = 0; i < 3; i++)
      step(0, 6'b100011, 6'd0, 5'd0, E_MRD, $sformatf("lw2_rd%0d", i));
    step(0, 6'b100011, 6'd0, 5'd0, E_MWB,  "lw2_wb");
    step(0, 6'b100011, 6'd0, 5'd0, E_F,    "lw2_next");

    // sw with MEM_WAIT = 3, reset during the 2nd write cycle restarts a full fetch
    sel = 2;
    step(1, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_f0");
    step(0, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_f1");
    step(0, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_f2");
    step(0, 6'b101011, 6'd0, 5'd0, E_FL,   "sw3_f3");
    step(0, 6'b101011, 6'd0, 5'd0, E_DEC,  "sw3_dec");
    step(0, 6'b101011, 6'd0, 5'd0, E_MADR, "sw3_adr");
    step(0, 6'b101011, 6'd0, 5'd0, E_MWR,  "sw3_wr0");
    step(0, 6'b101011, 6'd0, 5'd0, E_MWR,  "sw3_wr1");
    step(1, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_rst");
    step(0, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_rf1");
    step(0, 6'b101011, 6'd0, 5'd0, E_F,    "sw3_rf2");
    step(0, 6'b101011, 6'd0, 5'd0, E_FL,   "sw3_rf3");
    step(0, 6'b101011, 6'd0, 5'd0, E_DEC,  "sw3_rdec");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
